// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that shares one fixed-latency memory port
// between icache fills and dcache fills/writebacks.
module mem_arbiter #(
   parameter int LATENCY = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ic_req_valid,
   input  logic [19:0]  ic_req_addr,
   output logic         ic_resp_valid,
   output logic [127:0] ic_resp_data,
   input  logic         dc_req_valid,
   input  logic         dc_req_write,
   input  logic [19:0]  dc_req_addr,
   input  logic [127:0] dc_req_wdata,
   output logic         dc_resp_valid,
   output logic [127:0] dc_resp_data,
   output logic         mem_req_valid,
   output logic         mem_we,
   output logic [19:0]  mem_addr,
   output logic [127:0] mem_wdata,
   input  logic [127:0] mem_rdata,
   output logic         busy
);
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   state_t state_q, state_d;
   logic prio_q, prio_d, gnt_q, gnt_d, we_q, we_d, req_q, req_d, mwe_q, mwe_d;
   logic ic_rv_q, ic_rv_d, dc_rv_q, dc_rv_d, busy_q, busy_d, pick_dc;
   logic [3:0] cnt_q, cnt_d;
   logic [19:0] addr_q, addr_d;
   logic [127:0] wdata_q, wdata_d, ic_rd_q, ic_rd_d, dc_rd_q, dc_rd_d;
   // prio_q and gnt_q use 1 for the dcache
   assign pick_dc = dc_req_valid & (prio_q | ~ic_req_valid);
   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      gnt_d   = gnt_q;
      we_d    = we_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ic_rd_d = ic_rd_q;
      dc_rd_d = dc_rd_q;
      req_d   = 1'b0;
      mwe_d   = 1'b0;
      ic_rv_d = 1'b0;
      dc_rv_d = 1'b0;
      case (state_q)
         IDLE: if (ic_req_valid | dc_req_valid) begin
            state_d = BUSY;
            gnt_d   = pick_dc;
            prio_d  = ~pick_dc;
            addr_d  = (pick_dc ? dc_req_addr : ic_req_addr) & 20'hFFFF0;
            we_d    = pick_dc & dc_req_write;
            wdata_d = pick_dc ? dc_req_wdata : '0;
            cnt_d   = 4'(LATENCY);
            req_d   = 1'b1;
            mwe_d   = pick_dc & dc_req_write;
         end
         BUSY: if (cnt_q == 4'd0) begin
            state_d = RESP;
            ic_rv_d = ~gnt_q;
            dc_rv_d = gnt_q;
            ic_rd_d = gnt_q ? ic_rd_q : mem_rdata;
            dc_rd_d = gnt_q ? (we_q ? '0 : mem_rdata) : dc_rd_q;
         end else begin
            cnt_d = cnt_q - 4'd1;
         end
         default: state_d = IDLE;
      endcase
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         prio_q  <= 1'b1;
         gnt_q   <= 1'b0;
         we_q    <= 1'b0;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         ic_rd_q <= '0;
         dc_rd_q <= '0;
         req_q   <= 1'b0;
         mwe_q   <= 1'b0;
         ic_rv_q <= 1'b0;
         dc_rv_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         gnt_q   <= gnt_d;
         we_q    <= we_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ic_rd_q <= ic_rd_d;
         dc_rd_q <= dc_rd_d;
         req_q   <= req_d;
         mwe_q   <= mwe_d;
         ic_rv_q <= ic_rv_d;
         dc_rv_q <= dc_rv_d;
         busy_q  <= busy_d;
      end
   end
   assign ic_resp_valid = ic_rv_q;
   assign ic_resp_data  = ic_rd_q;
   assign dc_resp_valid = dc_rv_q;
   assign dc_resp_data  = dc_rd_q;
   assign mem_req_valid = req_q;
   assign mem_we        = mwe_q;
   assign mem_addr      = addr_q;
   assign mem_wdata     = wdata_q;
   assign busy          = busy_q;
endmodule
